debug_trace_fifo: RTL and testbench
===================================

DEBUG_TRACE_FIFO -- requirements
Module: debug_trace_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 16, FIFO entries; power of two, 4..64.
REQ-002 SHALL have parameter CNT_W, default $clog2(DEPTH)+1, occupancy width.
REQ-003 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous reset, active-high.
REQ-005 SHALL have port stage_vld_i  input  4  stage valids {aggr, sm, dmvm, spmm} at bits [3:0].
REQ-006 SHALL have ports debug_1_i, debug_2_i, debug_3_i  input  32 each  debug words to capture.
REQ-007 SHALL have port arm_i  input  1  start-capture pulse.
REQ-008 SHALL have port disarm_i  input  1  stop-capture pulse.
REQ-009 SHALL have port rd_rdy_i  input  1  reader accepts head entry.
REQ-010 SHALL have port rd_vld_o  output  1  head entry valid.
REQ-011 SHALL have port rd_data_o  output  128  [127:124] event mask, [123:108] timestamp, [107:96] zero, [95:64] debug_1, [63:32] debug_2, [31:0] debug_3.
REQ-012 SHALL have port count_o  output  CNT_W  stored entries.
REQ-013 SHALL have port overflow_o  output  1  sticky; an event was dropped.
REQ-014 SHALL have port state_o  output  2  FSM state: IDLE=0, ARMED=1, FULL=2.

Function
REQ-015 SHALL register stage_vld_i each cycle; event mask = stage_vld_i & ~stage_vld_q (rising edges).
REQ-016 SHALL in ARMED, when mask is nonzero, write {mask, timestamp, 12'b0, debug_1_i, debug_2_i, debug_3_i} as sampled that cycle.
REQ-017 SHALL not write in IDLE or FULL; events in IDLE are ignored without flag.
REQ-018 SHALL set overflow_o the cycle after a nonzero mask occurs in FULL with no pop that cycle.
REQ-019 SHALL set rd_vld_o = (count_o != 0); rd_data_o = head entry; pop when rd_vld_o && rd_rdy_i.
REQ-020 SHALL show a written entry on rd_vld_o/rd_data_o one cycle after the write cycle (write-to-read latency 1).
REQ-021 SHALL, with push and pop the same cycle, perform both and leave count_o unchanged.
REQ-022 SHALL wrap read and write pointers modulo DEPTH.
REQ-023 SHALL move IDLE->ARMED on arm_i; arm_i SHALL clear overflow_o and the timestamp but SHALL NOT clear FIFO contents.
REQ-024 SHALL move ARMED->FULL when a push without pop makes count reach DEPTH.
REQ-025 SHALL move FULL->ARMED on the first pop, if not disarmed; a same-cycle pop and event in FULL SHALL store the event.
REQ-026 SHALL move any state->IDLE on disarm_i; disarm_i wins over a same-cycle arm_i and suppresses that cycle's write.
REQ-027 SHALL ignore arm_i in ARMED or FULL.
REQ-028 SHALL keep reads operating in every state.

Reset
REQ-029 SHALL on rst: state IDLE, pointers 0, count_o 0, rd_vld_o 0, overflow_o 0, stage_vld_q 0, timestamp 0.
REQ-030 SHALL, on rst mid-operation, discard all stored entries; rd_data_o content after reset is don't-care while rd_vld_o=0.

Configuration
REQ-031 SHALL implement macro DEBUG_TRACE_TIMESTAMP_EN: when defined, a 16-bit free-running counter cleared on arm_i increments every cycle in ARMED/FULL, wraps 0xFFFF->0, and fills [123:108].
REQ-032 SHALL, without DEBUG_TRACE_TIMESTAMP_EN, omit the counter and tie [123:108] to zero.

Verification
REQ-033 SHALL check: arm, spmm valid 0->1 with debug_1=0x0000_1234 -> next cycle rd_vld_o=1, mask=4'b0001, [95:64]=0x0000_1234.
REQ-034 SHALL check: 17 events with DEPTH=16, no reads -> count_o=16, state_o=2, overflow_o=1, first entry intact.
REQ-035 SHALL check: full FIFO, rd_rdy_i=1 with an event the same cycle -> count_o stays 16, state_o=1, overflow_o unchanged.
REQ-036 SHALL check: arm_i and disarm_i together with an event -> state_o=0, count_o unchanged.
REQ-037 SHALL check: with DEBUG_TRACE_TIMESTAMP_EN, event 5 cycles after arm -> timestamp=5; without the macro -> 0.
REQ-038 SHALL check: rst asserted with count_o=7 -> count_o=0, rd_vld_o=0, state_o=0 immediately.

Source files
------------

// File: rtl/debug_trace_fifo.sv
// Debug trace capture FIFO: rising edges on stage valids are logged with three debug words.
// Optional DEBUG_TRACE_TIMESTAMP_EN adds a 16-bit timestamp in rd_data_o[123:108].
module debug_trace_fifo #(
  parameter int DEPTH = 16,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        stage_vld_i,
  input  logic [31:0]       debug_1_i,
  input  logic [31:0]       debug_2_i,
  input  logic [31:0]       debug_3_i,
  input  logic              arm_i,
  input  logic              disarm_i,
  input  logic              rd_rdy_i,
  output logic              rd_vld_o,
  output logic [127:0]      rd_data_o,
  output logic [CNT_W-1:0]  count_o,
  output logic              overflow_o,
  output logic [1:0]        state_o
);
  localparam int PTR_W = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE = 2'd0, ARMED = 2'd1, FULL = 2'd2} state_e;

  state_e             state_q;
  logic [3:0]         stage_vld_q;
  logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               ovf_q;
  logic [15:0]        ts;
  logic [127:0]       mem [DEPTH];

  logic [3:0] mask;
  logic       evt, is_full, pop, capture, push, drop, arm_ok;

  assign mask    = stage_vld_i & ~stage_vld_q;
  assign evt     = |mask;
  assign is_full = (count_q == CNT_W'(DEPTH));
  assign pop     = rd_vld_o && rd_rdy_i;
  assign capture = (state_q != IDLE) && !disarm_i;
  // A pop in the same cycle frees the slot, so a full FIFO can still take the event.
  assign push    = capture && evt && (!is_full || pop);
  assign drop    = capture && evt && is_full && !pop;
  assign arm_ok  = (state_q == IDLE) && arm_i && !disarm_i;

`ifdef DEBUG_TRACE_TIMESTAMP_EN
  logic [15:0] ts_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                   ts_q <= '0;
    else if (arm_ok)           ts_q <= '0;
    else if (state_q != IDLE)  ts_q <= ts_q + 16'd1;
  end
  assign ts = ts_q;
`else
  assign ts = '0;
`endif

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      stage_vld_q <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      ovf_q       <= 1'b0;
    end else begin
      stage_vld_q <= stage_vld_i;
      count_q     <= count_d;
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);

      if (drop)        ovf_q <= 1'b1;
      else if (arm_ok) ovf_q <= 1'b0;

      if (disarm_i) state_q <= IDLE;
      else begin
        case (state_q)
          IDLE:    if (arm_i) state_q <= ARMED;
          // Entering FULL also covers a drop while already at DEPTH after a pop+push.
          ARMED:   if ((push && !pop && count_q == CNT_W'(DEPTH - 1)) || drop) state_q <= FULL;
          FULL:    if (pop) state_q <= ARMED;
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= {mask, ts, 12'h000, debug_1_i, debug_2_i, debug_3_i};
  end

  assign rd_vld_o   = (count_q != '0);
  assign rd_data_o  = mem[rd_ptr_q];
  assign count_o    = count_q;
  assign overflow_o = ovf_q;
  assign state_o    = state_q;
endmodule

// File: tb/tb_debug_trace_fifo.sv
// Scoreboard bench for debug_trace_fifo (DEPTH=16): stimulus pushes expected entries, monitor pops on read handshakes.
module tb_debug_trace_fifo;
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [3:0]   stage_vld = '0;
  logic [31:0]  d1 = '0, d2 = '0, d3 = '0;
  logic         arm = 1'b0, disarm = 1'b0, rd_rdy = 1'b0;
  logic         rd_vld;
  logic [127:0] rd_data;
  logic [4:0]   count;
  logic         ovf;
  logic [1:0]   state;

  int checks = 0;
  int failures = 0;
  logic [127:0] exp_q[$];

`ifdef DEBUG_TRACE_TIMESTAMP_EN
  localparam logic [127:0] CMP_MASK = ~({16'hFFFF, 108'h0});
  localparam logic [15:0]  EXP_TS5  = 16'd5;
`else
  localparam logic [127:0] CMP_MASK = ~128'h0;
  localparam logic [15:0]  EXP_TS5  = 16'd0;
`endif

  debug_trace_fifo #(.DEPTH(16)) dut (
    .clk(clk), .rst(rst), .stage_vld_i(stage_vld),
    .debug_1_i(d1), .debug_2_i(d2), .debug_3_i(d3),
    .arm_i(arm), .disarm_i(disarm), .rd_rdy_i(rd_rdy),
    .rd_vld_o(rd_vld), .rd_data_o(rd_data), .count_o(count),
    .overflow_o(ovf), .state_o(state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Handshake seen mid-cycle completes at the next rising edge.
  always @(negedge clk) begin
    if (!rst && rd_vld && rd_rdy) begin
      if (exp_q.size() == 0) chk("sb_unexpected_pop", rd_data, 128'h0 - 128'h1);
      else begin
        logic [127:0] e;
        e = exp_q.pop_front();
        chk("sb_entry", rd_data & CMP_MASK, e & CMP_MASK);
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic fire(input logic [3:0] m, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] c, input bit store, input logic rdy);
    stage_vld = m; d1 = a; d2 = b; d3 = c; rd_rdy = rdy;
    if (store) exp_q.push_back({m, 16'h0, 12'h0, a, b, c});
    tick();
  endtask

  task automatic quiet();
    stage_vld = '0; rd_rdy = 1'b0;
    tick();
  endtask

  task automatic ev(input logic [3:0] m, input logic [31:0] a, input bit store);
    fire(m, a, ~a, a ^ 32'h5A5A_5A5A, store, 1'b0);
    quiet();
  endtask

  task automatic drain();
    rd_rdy = 1'b1;
    for (int i = 0; i < 40 && count != 0; i++) tick();
    rd_rdy = 1'b0;
    chk("drain_count", 128'(count), 128'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) tick();
    chk("rst_count", 128'(count), 0);
    chk("rst_vld", 128'(rd_vld), 0);
    chk("rst_state", 128'(state), 0);
    chk("rst_ovf", 128'(ovf), 0);
    rst = 1'b0;
    tick();

    ev(4'b0001, 32'h1111_0000, 1'b0);
    chk("idle_ignore_count", 128'(count), 0);
    chk("idle_ignore_ovf", 128'(ovf), 0);

    arm = 1'b1; tick(); arm = 1'b0;
    chk("arm_state", 128'(state), 1);

    fire(4'b0001, 32'h0000_1234, 32'hBEEF_0001, 32'hCAFE_0001, 1'b1, 1'b0);
    chk("first_vld", 128'(rd_vld), 1);
    chk("first_mask", 128'(rd_data[127:124]), 128'(4'b0001));
    chk("first_d1", 128'(rd_data[95:64]), 128'h0000_1234);
    chk("first_zero", 128'(rd_data[107:96]), 0);
    quiet();

    for (int i = 1; i < 16; i++) ev(4'(i), 32'hA000_0000 + 32'(i), 1'b1);
    chk("fill_state", 128'(state), 2);
    ev(4'hF, 32'hDEAD_DEAD, 1'b0);
    chk("ovf_count", 128'(count), 16);
    chk("ovf_state", 128'(state), 2);
    chk("ovf_flag", 128'(ovf), 1);
    chk("ovf_head_d1", 128'(rd_data[95:64]), 128'h0000_1234);
    chk("ovf_head_mask", 128'(rd_data[127:124]), 1);

    fire(4'b0100, 32'hB000_0001, 32'hB000_0002, 32'hB000_0003, 1'b1, 1'b1);
    chk("full_pp_count", 128'(count), 16);
    chk("full_pp_state", 128'(state), 1);
    chk("full_pp_ovf", 128'(ovf), 1);
    quiet();

    drain();
    chk("drain_vld", 128'(rd_vld), 0);

    ev(4'b0010, 32'hC000_000A, 1'b1);
    fire(4'b1000, 32'hC000_000B, 32'h1, 32'h2, 1'b1, 1'b1);
    chk("pp_count", 128'(count), 1);
    quiet();

    arm = 1'b1; disarm = 1'b1;
    fire(4'b0001, 32'hE000_0000, 32'h0, 32'h0, 1'b0, 1'b0);
    arm = 1'b0; disarm = 1'b0;
    chk("armdis_state", 128'(state), 0);
    chk("armdis_count", 128'(count), 1);
    quiet();
    chk("idle_ovf_sticky", 128'(ovf), 1);

    drain();
    arm = 1'b1; tick(); arm = 1'b0;
    chk("rearm_state", 128'(state), 1);
    chk("rearm_ovf", 128'(ovf), 0);

    // Five idle cycles in ARMED after the arm edge, then the event.
    repeat (5) tick();
    fire(4'b0010, 32'h7777_0005, 32'h5, 32'h5, 1'b1, 1'b0);
    chk("timestamp", 128'(rd_data[123:108]), 128'(EXP_TS5));
    quiet();
    drain();
    chk("sb_empty", 128'(exp_q.size()), 0);

    for (int i = 0; i < 7; i++) ev(4'b0001, 32'hF000_0000 + 32'(i), 1'b1);
    chk("pre_rst_count", 128'(count), 7);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_count", 128'(count), 0);
    chk("mid_rst_vld", 128'(rd_vld), 0);
    chk("mid_rst_state", 128'(state), 0);
    exp_q.delete();
    tick();
    rst = 1'b0;
    tick();
    chk("post_rst_count", 128'(count), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
